// File: rtl/shift_reg_tap_if.sv
// Control/data bundle for shift_reg_tap.
//   master: drives clr, load, par_in, shift_en, dir, ser_in, tap_sel, out_en
//           and observes ser_out, ser_vld, par_out, fill_cnt, full
//   slave : the register itself (direction-reversed view)
interface shift_reg_tap_if #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 10
);
    localparam int TAP_W = $clog2(DEPTH);

    logic                     clr;
    logic                     load;
    logic [DEPTH*WIDTH-1:0]   par_in;
    logic                     shift_en;
    logic                     dir;
    logic [WIDTH-1:0]         ser_in;
    logic [TAP_W-1:0]         tap_sel;
    logic                     out_en;
    logic [WIDTH-1:0]         ser_out;
    logic                     ser_vld;
    logic [DEPTH*WIDTH-1:0]   par_out;
    logic [TAP_W:0]           fill_cnt;
    logic                     full;

    modport master (
        output clr, load, par_in, shift_en, dir, ser_in, tap_sel, out_en,
        input  ser_out, ser_vld, par_out, fill_cnt, full
    );

    modport slave (
        input  clr, load, par_in, shift_en, dir, ser_in, tap_sel, out_en,
        output ser_out, ser_vld, par_out, fill_cnt, full
    );
endinterface

// File: rtl/shift_reg_tap.sv
// Parametrised multi-bit shift register / delay line.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : shift_reg_tap_if.slave
//     clr/load/shift_en  stage update, priority clr > load > shift_en > hold
//     dir                0: ser_in enters stage 0 and moves up,
//                        1: ser_in enters stage DEPTH-1 and moves down
//     tap_sel/out_en     select registered serial output (clamped to DEPTH-1)
//     ser_out/ser_vld    registered tap output and its valid (out_en && full)
//     par_out            all stages straight from the stage registers
//     fill_cnt/full      shifts since clear, saturating at DEPTH
module shift_reg_tap #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    shift_reg_tap_if.slave bus
);
    localparam int TAP_W = $clog2(DEPTH);
    localparam logic [TAP_W:0]   FULL_CNT = (TAP_W+1)'(DEPTH);
    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(DEPTH-1);

    // stg[i] is stage i; packed so it maps 1:1 onto par_in/par_out slices
    logic [DEPTH-1:0][WIDTH-1:0] stg;
    logic [TAP_W:0]              fill_cnt;
    logic [TAP_W-1:0]            tap;
    logic [WIDTH-1:0]            ser_out;
    logic                        ser_vld;
    logic                        full;

    assign full = (fill_cnt == FULL_CNT);

    // Out-of-range selects read the last stage rather than undefined data
    assign tap = ({1'b0, bus.tap_sel} >= FULL_CNT) ? LAST_TAP : bus.tap_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg      <= '0;
            fill_cnt <= '0;
        end else if (bus.clr) begin
            stg      <= '0;
            fill_cnt <= '0;
        end else if (bus.load) begin
            stg      <= bus.par_in;
            fill_cnt <= FULL_CNT;
        end else if (bus.shift_en) begin
            if (!bus.dir)
                stg <= {stg[DEPTH-2:0], bus.ser_in};
            else
                stg <= {bus.ser_in, stg[DEPTH-1:1]};
            if (!full)
                fill_cnt <= fill_cnt + 1'b1;
        end
    end

    // Tap and valid sample the pre-edge stage contents and fill state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ser_out <= '0;
            ser_vld <= 1'b0;
        end else begin
            ser_out <= (!bus.clr && bus.out_en) ? stg[tap] : '0;
            ser_vld <= !bus.clr && bus.out_en && full;
        end
    end

    assign bus.ser_out  = ser_out;
    assign bus.ser_vld  = ser_vld;
    assign bus.par_out  = stg;
    assign bus.fill_cnt = fill_cnt;
    assign bus.full     = full;
endmodule

// File: tb/tb_shift_reg_tap.sv
module tb_shift_reg_tap;
    localparam int W  = 8;
    localparam int D  = 10;
    localparam int TW = $clog2(D);
    localparam int CW = D*W;

    typedef struct {
        logic [CW-1:0] par;
        logic [TW:0]   fill;
        logic          full;
        logic [W-1:0]  so;
        logic          sv;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   failures = 0;

    exp_t         exp_q[$];
    logic [W-1:0] mq[$];     // reference stages, mq[i] = stage i
    int           mfill;

    shift_reg_tap_if #(.WIDTH(W), .DEPTH(D)) bus ();

    shift_reg_tap #(.WIDTH(W), .DEPTH(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        repeat (D) mq.push_back('0);
        mfill = 0;
    endtask

    function automatic logic [CW-1:0] rnd_par();
        logic [CW-1:0] p;
        for (int i = 0; i < D; i++) p[i*W +: W] = W'($urandom);
        return p;
    endfunction

    // One clock edge of stimulus; the expected post-edge outputs go to the scoreboard.
    task automatic step(input logic c, input logic l, input logic [CW-1:0] p,
                        input logic s, input logic d, input logic [W-1:0] si,
                        input logic [TW-1:0] t, input logic oe);
        exp_t e;
        int   ti;
        @(negedge clk);
        bus.clr = c; bus.load = l; bus.par_in = p; bus.shift_en = s;
        bus.dir = d; bus.ser_in = si; bus.tap_sel = t; bus.out_en = oe;
        ti   = (int'(t) >= D) ? D-1 : int'(t);
        e.so = (!c && oe) ? mq[ti] : '0;
        e.sv = !c && oe && (mfill == D);
        if (c) model_reset();
        else if (l) begin
            mq.delete();
            for (int i = 0; i < D; i++) mq.push_back(p[i*W +: W]);
            mfill = D;
        end else if (s) begin
            if (!d) begin mq.push_front(si); void'(mq.pop_back());  end
            else    begin mq.push_back(si);  void'(mq.pop_front()); end
            mfill = (mfill < D) ? mfill + 1 : D;
        end
        for (int i = 0; i < D; i++) e.par[i*W +: W] = mq[i];
        e.fill = (TW+1)'(mfill);
        e.full = (mfill == D);
        exp_q.push_back(e);
    endtask

    task automatic idle_inputs();
        bus.clr = 0; bus.load = 0; bus.par_in = '0; bus.shift_en = 0;
        bus.dir = 0; bus.ser_in = '0; bus.tap_sel = '0; bus.out_en = 0;
    endtask

    // Park just after the edge so the monitor has already compared it
    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_par"},  bus.par_out, '0);
        chk({name, "_so"},   CW'(bus.ser_out), '0);
        chk({name, "_sv"},   CW'(bus.ser_vld), '0);
        chk({name, "_fill"}, CW'(bus.fill_cnt), '0);
        chk({name, "_full"}, CW'(bus.full), '0);
    endtask

    // Monitor: every edge that stimulus was issued for, pop and compare.
    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_par_out",  bus.par_out, e.par);
            chk("sb_fill_cnt", CW'(bus.fill_cnt), CW'(e.fill));
            chk("sb_full",     CW'(bus.full), CW'(e.full));
            chk("sb_ser_out",  CW'(bus.ser_out), CW'(e.so));
            chk("sb_ser_vld",  CW'(bus.ser_vld), CW'(e.sv));
        end
    end

    initial begin
        logic [CW-1:0] p;
        logic [CW-1:0] want;
        idle_inputs();
        model_reset();
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // 1: single 1 travels to tap 9, seen exactly once after the 11th edge
        for (int k = 0; k < 15; k++) begin
            step(0, 0, '0, 1, 0, (k == 0) ? W'(1) : W'(0), TW'(D-1), 1);
            settle();
            chk("t1_ser_out", CW'(bus.ser_out), (k == 10) ? CW'(1) : CW'(0));
            chk("t1_ser_vld", CW'(bus.ser_vld), (k >= 10) ? CW'(1) : CW'(0));
        end

        // 2: parallel load i+1, sweep taps, then out-of-range clamps
        for (int i = 0; i < D; i++) p[i*W +: W] = W'(i+1);
        step(0, 1, p, 0, 0, '0, '0, 0);
        for (int t = 0; t < D + 2; t++) begin
            step(0, 0, '0, 0, 0, '0, (t < D) ? TW'(t) : TW'(t + 2), 1);
            settle();
            chk("t2_tap", CW'(bus.ser_out), (t < D) ? CW'(t+1) : CW'(D));
        end

        // 3: load then shift down three times with 0xAA
        step(0, 1, p, 0, 0, '0, '0, 0);
        repeat (3) step(0, 0, '0, 1, 1, W'(8'hAA), '0, 0);
        settle();
        for (int i = 0; i < D; i++) want[i*W +: W] = (i < 7) ? W'(i+4) : W'(8'hAA);
        chk("t3_par_out", bus.par_out, want);
        chk("t3_fill", CW'(bus.fill_cnt), CW'(D));

        // 4: clr beats load, load beats shift
        step(1, 1, rnd_par(), 1, 0, W'(8'h55), '0, 1);
        settle();
        chk("t4_clr_par", bus.par_out, '0);
        chk("t4_clr_fill", CW'(bus.fill_cnt), '0);
        p = rnd_par();
        step(0, 1, p, 1, 0, W'(8'h55), '0, 0);
        settle();
        chk("t4_load_par", bus.par_out, p);
        chk("t4_load_fill", CW'(bus.fill_cnt), CW'(D));

        // 5: async reset at fill 5, then full only after 10 further shifts
        step(1, 0, '0, 0, 0, '0, '0, 1);
        repeat (5) step(0, 0, '0, 1, 0, W'($urandom), TW'(2), 1);
        settle();
        chk("t5_pre_fill", CW'(bus.fill_cnt), CW'(5));
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        #1;
        chk_all_zero("t5_async");
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < D; k++) begin
            step(0, 0, '0, 1, 0, W'($urandom), TW'(D-1), 1);
            settle();
            chk("t5_full", CW'(bus.full), (k == D-1) ? CW'(1) : CW'(0));
        end

        // 6: out_en toggling while shifting in both directions
        step(0, 1, rnd_par(), 0, 0, '0, '0, 0);
        for (int k = 0; k < 20; k++) begin
            step(0, 0, '0, 1, 1'($urandom), W'($urandom), TW'($urandom_range(0, 15)), 1'(k % 2));
            settle();
            if (k % 2 == 0) chk("t6_gate", CW'(bus.ser_out), '0);
        end

        // Random soak against the reference model
        for (int k = 0; k < 400; k++)
            step($urandom_range(0, 19) == 0, $urandom_range(0, 14) == 0, rnd_par(),
                 $urandom_range(0, 3) != 0, 1'($urandom), W'($urandom),
                 TW'($urandom_range(0, 15)), 1'($urandom));
        settle();
        settle();
        chk("sb_drained", CW'(exp_q.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
